nest_counter_gen: RTL and testbench

- Runtime-configurable N-level nested loop counter with a start/done handshake and an integrated address generator.
- Generalises the fixed 4-level, compile-time-bound tile counter:
  - level count is a parameter;
  - bounds and strides are loaded per run;
  - the consumer advances the count with a flow-controlled `ena`;
  - a linear address (base + Σ cnt_i·stride_i) is produced without multipliers.
- Sits between the tile scheduler (issues `start` with the tile geometry) and the on-chip buffer read/write ports (consume `addr`/`cnt`).

---
 rtl/nest_counter_gen_pkg.sv | 15 +
 rtl/nest_counter_gen_level.sv | 58 +++++
 rtl/nest_counter_gen.sv | 106 ++++++++++
 tb/tb_nest_counter_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nest_counter_gen_pkg.sv
// Shared definitions for the nested loop counter: FSM encoding and the
// offset helper used to slice the packed per-level buses.
package nest_counter_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lowest bit of level `level` inside a packed bus of `width`-bit fields.
    function automatic int slice_lsb(input int level, input int width);
        return level * width;
    endfunction

endpackage

// File: rtl/nest_counter_gen_level.sv
// One loop level: trip counter, wrap compare and the address register that
// remembers where this level's current iteration started.
module nest_level
    import nest_counter_gen_pkg::*;
#(
    parameter int CW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          adv,
    input  logic          clr,
    input  logic          carry_in,
    input  logic [CW-1:0] max_in,
    input  logic [AW-1:0] stride_in,
    input  logic [AW-1:0] base_in,
    input  logic [AW-1:0] addr_above,
    output logic          carry_out,
    output logic [CW-1:0] cnt,
    output logic [AW-1:0] lvl_addr,
    output logic [AW-1:0] addr_below
);

    logic [CW-1:0] max_r;
    logic [AW-1:0] stride_r;
    logic          at_last;
    logic          is_step;

    assign at_last   = (cnt == (max_r - CW'(1)));
    assign is_step   = carry_in & ~at_last;
    assign carry_out = carry_in & at_last;

    // The stepping level produces the new address; every wrapping level
    // below it restarts from that same value.
    assign addr_below = is_step ? (lvl_addr + stride_r) : addr_above;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_r    <= '0;
            stride_r <= '0;
            cnt      <= '0;
            lvl_addr <= '0;
        end else if (load) begin
            // A zero bound behaves as a single-iteration level.
            max_r    <= (max_in == '0) ? CW'(1) : max_in;
            stride_r <= stride_in;
            cnt      <= '0;
            lvl_addr <= base_in;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv && carry_in) begin
            cnt      <= at_last ? '0 : (cnt + CW'(1));
            lvl_addr <= addr_below;
        end
    end

endmodule

// File: rtl/nest_counter_gen.sv
// Runtime-configurable nested loop counter with address generation.
// Handshake: a tuple is consumed on every cycle where valid && ena.
module nest_counter_gen
    import nest_counter_gen_pkg::*;
#(
    parameter int NEST = 4,
    parameter int CW   = 16,
    parameter int AW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NEST*CW-1:0] cfg_max,
    input  logic [NEST*AW-1:0] cfg_stride,
    input  logic [AW-1:0]      cfg_base,
    input  logic               ena,
    output logic               valid,
    output logic [NEST*CW-1:0] cnt,
    output logic [AW-1:0]      addr,
    output logic [NEST-1:0]    last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t state, state_n;
    logic   done_n, err_n;
    logic   accept, step, adv, final_step, any_zero;

    logic [NEST:0]   carry;
    logic [AW-1:0]   addr_chain [NEST+1];
    logic [AW-1:0]   lvl_addr   [NEST];

    assign valid      = (state == RUN);
    assign busy       = valid;
    assign accept     = (state == IDLE) && start;
    assign step       = valid && ena;
    assign final_step = step && carry[NEST];
    assign adv        = step && !carry[NEST];

    assign carry[0]         = 1'b1;
    assign addr_chain[NEST] = '0;
    assign addr             = lvl_addr[0];
    assign last             = valid ? carry[NEST:1] : '0;

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NEST; i++) begin
            if (cfg_max[slice_lsb(i, CW) +: CW] == '0) any_zero = 1'b1;
        end
    end

    genvar g;
    for (g = 0; g < NEST; g++) begin : g_level
        nest_level #(.CW(CW), .AW(AW)) u_level (
            .clk        (clk),
            .rst        (rst),
            .load       (accept),
            .adv        (adv),
            .clr        (final_step),
            .carry_in   (carry[g]),
            .max_in     (cfg_max[slice_lsb(g, CW) +: CW]),
            .stride_in  (cfg_stride[slice_lsb(g, AW) +: AW]),
            .base_in    (cfg_base),
            .addr_above (addr_chain[g+1]),
            .carry_out  (carry[g+1]),
            .cnt        (cnt[slice_lsb(g, CW) +: CW]),
            .lvl_addr   (lvl_addr[g]),
            .addr_below (addr_chain[g])
        );
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_n   = cfg_err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    err_n   = any_zero;
                end
            end
            RUN: begin
                if (final_step) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= done_n;
            cfg_err <= err_n;
        end
    end

endmodule

// File: tb/tb_nest_counter_gen.sv
// Scoreboard bench for nest_counter_gen: drivers push expected tuples, a
// negedge monitor pops and compares them as the DUT consumes each tuple.
module tb_nest_counter_gen;

    localparam int NEST = 4;
    localparam int CW   = 16;
    localparam int AW   = 32;
    localparam int TW   = NEST + AW + NEST * CW;

    logic               clk;
    logic               rst;
    logic               start;
    logic [NEST*CW-1:0] cfg_max;
    logic [NEST*AW-1:0] cfg_stride;
    logic [AW-1:0]      cfg_base;
    logic               ena;
    logic               valid;
    logic [NEST*CW-1:0] cnt;
    logic [AW-1:0]      addr;
    logic [NEST-1:0]    last;
    logic               busy;
    logic               done;
    logic               cfg_err;

    logic [TW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    bit pending_done = 1'b0;
    bit ena_rand = 1'b0;

    int          cur_max    [NEST];
    logic [AW-1:0] cur_stride [NEST];
    logic [AW-1:0] cur_base;

    nest_counter_gen #(.NEST(NEST), .CW(CW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_max    (cfg_max),
        .cfg_stride (cfg_stride),
        .cfg_base   (cfg_base),
        .ena        (ena),
        .valid      (valid),
        .cnt        (cnt),
        .addr       (addr),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // Clock and reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Driver tasks
    task automatic set_cfg(input int m0, input int m1, input int m2, input int m3,
                           input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                           input logic [AW-1:0] s2, input logic [AW-1:0] s3,
                           input logic [AW-1:0] b);
        cur_max[0] = m0; cur_max[1] = m1; cur_max[2] = m2; cur_max[3] = m3;
        cur_stride[0] = s0; cur_stride[1] = s1; cur_stride[2] = s2; cur_stride[3] = s3;
        cur_base   = b;
        cfg_max    = {CW'(m3), CW'(m2), CW'(m1), CW'(m0)};
        cfg_stride = {s3, s2, s1, s0};
        cfg_base   = b;
    endtask

    task automatic push_tuple(input logic [NEST*CW-1:0] c, input logic [AW-1:0] a,
                              input logic [NEST-1:0] l);
        exp_q.push_back({l, a, c});
    endtask

    // Reference sequence: tuple n is n written in mixed radix, level 0 fastest.
    task automatic push_model();
        int m [NEST];
        int c [NEST];
        int total;
        int dv;
        logic [NEST*CW-1:0] cv;
        logic [AW-1:0]      a;
        logic [NEST-1:0]    l;
        bit                 all_last;
        total = 1;
        for (int i = 0; i < NEST; i++) begin
            m[i] = (cur_max[i] == 0) ? 1 : cur_max[i];
            total = total * m[i];
        end
        for (int n = 0; n < total; n++) begin
            dv = 1;
            a = cur_base;
            all_last = 1'b1;
            for (int i = 0; i < NEST; i++) begin
                c[i] = (n / dv) % m[i];
                dv = dv * m[i];
                a = a + cur_stride[i] * AW'(c[i]);
                cv[i*CW +: CW] = CW'(c[i]);
                all_last = all_last && (c[i] == m[i] - 1);
                l[i] = all_last;
            end
            push_tuple(cv, a, l);
        end
    endtask

    task automatic start_run(input bit check_err);
        bit exp_err;
        exp_err = 1'b0;
        for (int i = 0; i < NEST; i++) if (cur_max[i] == 0) exp_err = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (check_err) chk("cfg_err_after_start", cfg_err, exp_err);
        cfg_max    = {$urandom, $urandom};
        cfg_stride = {$urandom, $urandom, $urandom, $urandom};
        cfg_base   = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("run_completes_in_budget", n < 3000, 1'b1);
        @(negedge clk); #1;
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("handshake_reached", hs_count >= target, 1'b1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            ena = ena_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor
    initial begin
        logic [TW-1:0]      exp;
        logic               prev_valid;
        logic               prev_ena;
        logic [NEST*CW-1:0] prev_cnt;
        logic [AW-1:0]      prev_addr;
        prev_valid = 1'b0;
        prev_ena   = 1'b0;
        prev_cnt   = '0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (pending_done) begin
                chk("done_pulse", {done, busy, valid, cnt}, {1'b1, 1'b0, 1'b0, {NEST*CW{1'b0}}});
                pending_done = 1'b0;
            end else if (done) begin
                chk("spurious_done", done, 1'b0);
            end
            if (prev_valid && !prev_ena && valid) begin
                chk("hold_while_stalled", {cnt, addr}, {prev_cnt, prev_addr});
            end
            if (valid && ena) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tuple", {last, addr, cnt}, '0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("tuple", {last, addr, cnt}, exp);
                    if (exp[TW-1]) pending_done = 1'b1;
                end
                hs_count++;
            end
            prev_valid = valid;
            prev_ena   = ena;
            prev_cnt   = cnt;
            prev_addr  = addr;
        end
    end

    initial begin
        int h0;
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        ena        = 1'b0;
        cfg_max    = '0;
        cfg_stride = '0;
        cfg_base   = '0;
        #12;
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_cnt", cnt, '0);
        chk("reset_addr", addr, '0);
        chk("reset_last", last, '0);
        chk("reset_cfg_err", cfg_err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // 48-tuple sweep with ena held high: addr runs 0x100..0x12F
        set_cfg(4, 2, 2, 3, 1, 4, 8, 16, 32'h100);
        push_model();
        h0 = hs_count;
        start_run(1'b1);
        wait_idle();
        chk("sweep_handshakes", hs_count - h0, 48);

        // Same sweep under random ena, with an ignored start mid-run
        ena_rand = 1'b1;
        set_cfg(4, 2, 2, 3, 1, 4, 8, 16, 32'h100);
        push_model();
        h0 = hs_count;
        start_run(1'b1);
        wait_hs(h0 + 5);
        cfg_max = '0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("midrun_start_busy", busy, 1'b1);
        chk("midrun_start_cfg_err", cfg_err, 1'b0);
        wait_idle();
        chk("random_ena_handshakes", hs_count - h0, 48);
        ena_rand = 1'b0;

        // All bounds 1: one tuple, done two cycles after start
        set_cfg(1, 1, 1, 1, 5, 6, 7, 8, 32'h2000);
        push_tuple('0, 32'h2000, 4'b1111);
        start_run(1'b1);
        @(posedge clk); #1;
        chk("single_done_latency", done, 1'b1);
        wait_idle();

        // Zero bound on level 1, then a clean config clears cfg_err
        set_cfg(3, 0, 2, 1, 1, 5, 3, 9, 32'h300);
        push_model();
        h0 = hs_count;
        start_run(1'b1);
        wait_idle();
        chk("zero_bound_tuples", hs_count - h0, 6);
        chk("cfg_err_sticky", cfg_err, 1'b1);
        set_cfg(2, 2, 2, 2, 1, 2, 4, 8, 32'h40);
        push_model();
        start_run(1'b1);
        wait_idle();

        // Back-to-back runs: start issued in the done cycle
        set_cfg(2, 1, 1, 1, 3, 0, 0, 0, 32'h10);
        push_model();
        start_run(1'b0);
        set_cfg(3, 1, 1, 1, 2, 0, 0, 0, 32'h80);
        push_model();
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_done_seen", done, 1'b1);
        chk("b2b_bubble_valid", valid, 1'b0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("b2b_second_valid", valid, 1'b1);
        wait_idle();

        // Reset after tuple 10, then a fresh replay
        set_cfg(4, 2, 2, 3, 1, 4, 8, 16, 32'h100);
        push_model();
        h0 = hs_count;
        start_run(1'b0);
        wait_hs(h0 + 10);
        rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", {valid, busy, done, last, cnt, addr}, '0);
        exp_q.delete();
        pending_done = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        set_cfg(4, 2, 2, 3, 1, 4, 8, 16, 32'h100);
        push_model();
        start_run(1'b1);
        wait_idle();

        // Address wrap modulo 2^32
        set_cfg(4, 1, 1, 1, 1, 0, 0, 0, 32'hFFFF_FFFE);
        push_tuple(64'h0, 32'hFFFF_FFFE, 4'b0000);
        push_tuple(64'h1, 32'hFFFF_FFFF, 4'b0000);
        push_tuple(64'h2, 32'h0000_0000, 4'b0000);
        push_tuple(64'h3, 32'h0000_0001, 4'b1111);
        start_run(1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
